// File: rtl/ecd_addr_gen_mlane.sv
// ecd_addr_gen_mlane
// Multi-lane rearrange address generator. On start it walks the rotation
// group ROTATE_BASE^k mod 2N for k = 0..N/2-1 and emits LANES consecutive
// elements per beat as (slot address, real/imag select) pairs.
//
// Output handshake: a beat transfers on a rising edge where out_vld and
// out_rdy are both high. While out_vld is high and out_rdy is low the beat
// (out_addr, out_im, out_last) holds stable and the generator does not
// advance. out_vld never drops without a transfer except on reset.
module ecd_addr_gen_mlane #(
    parameter int POLY_POWER  = 8192,
    parameter int ROTATE_BASE = 3,
    parameter int LANES       = 2,
    parameter int ADDR_WIDTH  = $clog2(POLY_POWER / 2)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        conj,
    output logic                        busy,
    output logic                        done,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [LANES*ADDR_WIDTH-1:0] out_addr,
    output logic [LANES-1:0]            out_im,
    output logic                        out_last,
    output logic [1:0]                  dbg_state
);

    // Width of a residue mod 2N, and number of beats per sequence.
    localparam int MOD_W     = $clog2(2 * POLY_POWER);
    localparam int NUM_BEATS = POLY_POWER / (2 * LANES);
    localparam int CNT_W     = $clog2(NUM_BEATS) + 1;

    // ROTATE_BASE^k mod 2N; 2N is a power of two so truncation is the modulo.
    function automatic logic [MOD_W-1:0] base_pow(input int k);
        logic [MOD_W-1:0] r;
        logic [MOD_W-1:0] b;
        b = MOD_W'(ROTATE_BASE);
        r = MOD_W'(1);
        for (int j = 0; j < k; j++) begin
            r = r * b;
        end
        return r;
    endfunction

    localparam logic [MOD_W-1:0] C_STEP = base_pow(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [MOD_W-1:0]            pow_q, pow_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        conj_q, conj_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        vld_q, vld_d;
    logic [LANES*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LANES-1:0]            im_q, im_d;
    logic                        last_q, last_d;

    logic [MOD_W-1:0]            pow_sel;
    logic                        conj_sel;
    logic [LANES*ADDR_WIDTH-1:0] lane_addr;
    logic [LANES-1:0]            lane_im;

    // The first beat is built in IDLE from pow=1 and the live conj input so it
    // is valid in the cycle right after start is accepted.
    always_comb begin
        pow_sel  = (state_q == IDLE) ? MOD_W'(1) : pow_q;
        conj_sel = (state_q == IDLE) ? conj : conj_q;
    end

    // Per-lane element: p = pow * ROTATE_BASE^i, t = (p-1)>>1 (p is odd, so
    // this is p without its LSB). Upper half of t folds back as N-1-t, which is
    // the bitwise complement of t's low ADDR_WIDTH bits.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [MOD_W-1:0] LANE_C = base_pow(gi);
        logic [MOD_W-1:0]  p;
        logic [ADDR_WIDTH:0] t;
        assign p = pow_sel * LANE_C;
        assign t = p[MOD_W-1:1];
        assign lane_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            t[ADDR_WIDTH] ? ~t[ADDR_WIDTH-1:0] : t[ADDR_WIDTH-1:0];
        assign lane_im[gi] = ~t[ADDR_WIDTH] ^ conj_sel;
    end

    // Next-state logic for the sequencer and the output beat register.
    always_comb begin
        state_d = state_q;
        pow_d   = pow_q;
        cnt_d   = cnt_q;
        conj_d  = conj_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        vld_d   = vld_q;
        addr_d  = addr_q;
        im_d    = im_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    conj_d  = conj;
                    busy_d  = 1'b1;
                    vld_d   = 1'b1;
                    addr_d  = lane_addr;
                    im_d    = lane_im;
                    last_d  = (NUM_BEATS == 1);
                    pow_d   = C_STEP;
                    cnt_d   = CNT_W'(1);
                end
            end
            RUN: begin
                if (vld_q && last_q) begin
                    if (out_rdy) begin
                        state_d = FIN;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (!vld_q || out_rdy) begin
                    vld_d  = 1'b1;
                    addr_d = lane_addr;
                    im_d   = lane_im;
                    last_d = (cnt_q == CNT_W'(NUM_BEATS - 1));
                    pow_d  = pow_q * C_STEP;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pow_q   <= MOD_W'(1);
            cnt_q   <= '0;
            conj_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            addr_q  <= '0;
            im_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pow_q   <= pow_d;
            cnt_q   <= cnt_d;
            conj_q  <= conj_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            im_q    <= im_d;
            last_q  <= last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_vld   = vld_q;
    assign out_addr  = addr_q;
    assign out_im    = im_q;
    assign out_last  = last_q;
    assign dbg_state = state_q;

endmodule
